// File: rtl/led_pkg.sv
// led_pkg: shared LED channel constants and board polarity.
package led_pkg;
  localparam int NUM_LEDS = 6;
  localparam int PWM_BITS = 8;
  localparam int PWM_MAX = 255;
  localparam logic LED_ON = 1'b0;
  localparam logic LED_OFF = 1'b1;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED's duty ramp toward its target and registered PWM pin.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int DW = PWM_BITS
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          lit,
  input  logic [DW-1:0] max_level,
  input  logic          ramp_tick,
  input  logic [DW-1:0] pwm_cnt,
  output logic          pin,
  output logic          at_target
);
  logic [DW-1:0] duty;
  logic [DW-1:0] target;
  assign target = lit ? max_level : '0;
  assign at_target = duty == target;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      duty <= '0;
      pin <= LED_OFF;
    end else begin
      duty <= (ramp_tick && !at_target) ? ((duty < target) ? duty + 1'b1 : duty - 1'b1) : duty;
      pin <= (pwm_cnt < duty) ? LED_ON : LED_OFF;
    end
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: turns an active-low LED pattern into PWM pin drive with linear fades.
module led_pwm_fader #(
  parameter int NUM_LEDS = 6,
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 26470
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [PWM_BITS-1:0] max_level,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);
  import led_pkg::*;
  localparam int RW = $clog2(RAMP_DIV + 1);
  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] at_target;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [RW-1:0]       ramp_cnt;
  logic                ramp_tick;
  assign ramp_tick = ramp_cnt == RW'(RAMP_DIV - 1);
  // period is 2^PWM_BITS-1 so a full-scale duty keeps the pin permanently lit
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      led_q <= '1;
      pwm_cnt <= '0;
      ramp_cnt <= '0;
      busy <= 1'b0;
    end else begin
      led_q <= led_in;
      pwm_cnt <= (pwm_cnt == PWM_BITS'((1 << PWM_BITS) - 2)) ? '0 : pwm_cnt + 1'b1;
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
      busy <= ~&at_target;
    end
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel #(.DW(PWM_BITS)) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .lit       (led_q[i] == LED_ON),
      .max_level (max_level),
      .ramp_tick (ramp_tick),
      .pwm_cnt   (pwm_cnt),
      .pin       (led_out[i]),
      .at_target (at_target[i])
    );
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed fade, reversal, level-change, reset and edge-duty vectors.
module tb_led_pwm_fader;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [5:0] led_in = 6'h3f;
  logic [5:0] led_in_b = 6'h00;
  logic [7:0] max_level = 8'd255;
  logic [7:0] max_level_b = 8'd0;
  logic [5:0] led_out, led_out_b;
  logic       busy, busy_b;
  int n_vec = 0;
  int n_err = 0;
  int b_bad = 0;
  logic b_watch = 1'b0;

  led_pwm_fader #(.RAMP_DIV(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .led_in(led_in),
    .max_level(max_level), .led_out(led_out), .busy(busy)
  );
  led_pwm_fader #(.RAMP_DIV(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .led_in(led_in_b),
    .max_level(max_level_b), .led_out(led_out_b), .busy(busy_b)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk)
    if (b_watch && (led_out_b != 6'h3f || busy_b)) b_bad++;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output int k);
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (busy !== lvl && k < lim);
  endtask

  function automatic int d0();
    return int'(dut.g_ch[0].u_ch.duty);
  endfunction

  function automatic int d5();
    return int'(dut.g_ch[5].u_ch.duty);
  endfunction

  initial begin
    int k, k2, d, prev, bad, lows, highs;
    repeat (3) @(negedge sys_clk);
    chk("rst_led_out", led_out, 6'h3f);
    chk("rst_busy", busy, 0);
    chk("rst_duty0", d0(), 0);
    chk("rst_duty5", d5(), 0);
    sys_rst_n = 1'b1;
    b_watch = 1'b1;
    repeat (5) @(negedge sys_clk);
    led_in = 6'b111110;
    wait_busy(1'b1, 10, k);
    chk("fadein_busy_rise", int'(k <= 2 && busy), 1);
    wait_busy(1'b0, 2000, k2);
    chk("fadein_cycles_ok", int'(k + k2 >= 1016 && k + k2 <= 1028), 1);
    chk("fadein_duty0", d0(), 255);
    chk("fadein_duty5", d5(), 0);
    highs = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      if (led_out[0]) highs++;
    end
    chk("full_on_highs", highs, 0);
    led_in = 6'h3f;
    bad = 0;
    k = 0;
    do begin
      prev = d0();
      @(negedge sys_clk);
      k++;
      if (d0() != prev && d0() != prev - 1) bad++;
    end while ((busy || k < 3) && k < 1200);
    chk("fadeout_step", bad, 0);
    chk("fadeout_in_time", int'(k < 1200), 1);
    chk("fadeout_duty0", d0(), 0);
    lows = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      if (!led_out[0]) lows++;
    end
    chk("full_off_lows", lows, 0);
    led_in = 6'b111110;
    k = 0;
    while (d0() != 100 && k < 600) begin
      @(negedge sys_clk);
      k++;
    end
    chk("rev_reach100", d0(), 100);
    led_in = 6'h3f;
    @(negedge sys_clk);
    d = d0();
    k = 0;
    while (d0() == d && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    chk("rev_nojump", int'(d == 100 || d == 101), 1);
    chk("rev_step", d0(), d - 1);
    wait_busy(1'b0, 1000, k);
    chk("rev_settle0", d0(), 0);
    led_in = 6'h00;
    max_level = 8'd200;
    wait_busy(1'b1, 10, k);
    wait_busy(1'b0, 1000, k);
    chk("lvl200_duty0", d0(), 200);
    chk("lvl200_duty5", d5(), 200);
    max_level = 8'd50;
    wait_busy(1'b1, 10, k);
    wait_busy(1'b0, 1000, k2);
    chk("lvl50_cycles_ok", int'(k + k2 >= 594 && k + k2 <= 606), 1);
    chk("lvl50_duty5", d5(), 50);
    lows = 0;
    highs = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      if (led_out == 6'h00) lows++;
      if (led_out == 6'h3f) highs++;
    end
    chk("lvl50_low_cycles", lows, 50);
    chk("lvl50_high_cycles", highs, 205);
    max_level = 8'd255;
    repeat (20) @(negedge sys_clk);
    chk("pre_rst_busy", busy, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_led_out", led_out, 6'h3f);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_duty0", d0(), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_duty0", d0(), 0);
    repeat (300) @(negedge sys_clk);
    b_watch = 1'b0;
    chk("edge_dark_bad", b_bad, 0);
    max_level_b = 8'd3;
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (busy_b && k < 20);
    chk("div1_busy_fall", k, 4);
    chk("div1_duty", int'(dut_b.g_ch[2].u_ch.duty), 3);
    lows = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      if (led_out_b == 6'h00) lows++;
    end
    chk("div1_low_cycles", lows, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
